// File: rtl/vram_arbiter.sv
// Multi-channel VRAM arbiter: one access per cycle to a single-port VRAM, chosen either
// round-robin or by fixed TDM slots, with read data routed back to the requesting channel.
module vram_arbiter #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 640,
   parameter int ADDR_W = 9,
   parameter int RD_LAT = 1,
   parameter int MODE   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          req,
   input  logic [N_CH-1:0]          we,
   input  logic [N_CH*ADDR_W-1:0]   addr,
   input  logic [N_CH*DATA_W-1:0]   wdata,
   output logic [N_CH-1:0]          grant,
   output logic [N_CH-1:0]          rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic                     to_vram_en,
   output logic                     to_vram_wea,
   output logic [ADDR_W-1:0]        to_vram_addr,
   output logic [DATA_W-1:0]        to_vram_write,
   input  logic [DATA_W-1:0]        from_vram_read
);

   localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  slot_q, slot_d;
   logic [PTR_W-1:0]  gIdx, cand;
   logic              gValid;
   logic              en_q, en_d;
   logic              wea_q, wea_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] write_q, write_d;
   logic [N_CH-1:0]   rdPipe_q [0:RD_LAT];

   always_comb begin
      gValid = 1'b0;
      gIdx   = '0;
      cand   = '0;
      grant  = '0;
      if (MODE == 0) begin
         for (int i = 0; i < N_CH; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % N_CH);
            if (!gValid && req[cand]) begin
               gValid = 1'b1;
               gIdx   = cand;
            end
         end
      end else begin
         gIdx   = slot_q;
         gValid = req[slot_q];
      end
      if (!rst) begin
         gValid = 1'b0;
      end
      grant[gIdx] = gValid;
   end

   always_comb begin
      ptr_d   = ptr_q;
      slot_d  = (slot_q == PTR_W'(N_CH - 1)) ? '0 : slot_q + 1'b1;
      en_d    = gValid;
      wea_d   = gValid & we[gIdx];
      addr_d  = addr_q;
      write_d = write_q;
      if (gValid) begin
         ptr_d   = (gIdx == PTR_W'(N_CH - 1)) ? '0 : gIdx + 1'b1;
         addr_d  = addr[int'(gIdx)*ADDR_W +: ADDR_W];
         write_d = wdata[int'(gIdx)*DATA_W +: DATA_W];
      end
   end

   // Read tags ride a 1+RD_LAT deep pipe so they line up with the VRAM's read output.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q   <= '0;
         slot_q  <= '0;
         en_q    <= 1'b0;
         wea_q   <= 1'b0;
         addr_q  <= '0;
         write_q <= '0;
         for (int i = 0; i <= RD_LAT; i++) begin
            rdPipe_q[i] <= '0;
         end
      end else begin
         ptr_q       <= ptr_d;
         slot_q      <= slot_d;
         en_q        <= en_d;
         wea_q       <= wea_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         rdPipe_q[0] <= grant & ~we;
         for (int i = 1; i <= RD_LAT; i++) begin
            rdPipe_q[i] <= rdPipe_q[i-1];
         end
      end
   end

   assign rvalid        = rst ? rdPipe_q[RD_LAT] : '0;
   assign rdata         = from_vram_read;
   assign to_vram_en    = en_q;
   assign to_vram_wea   = wea_q;
   assign to_vram_addr  = addr_q;
   assign to_vram_write = write_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a cycle table for the default round-robin config plus
// hand sequences for TDM slots (N_CH=4) and pointer wrap (N_CH=3).
module tb_vram_arbiter;

   localparam int DW = 640;
   localparam int AW = 9;

   typedef struct {
      logic          rstN;
      logic [1:0]    req;
      logic [1:0]    we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [1:0]    expGrant;
      logic          expEn;
      logic          expWea;
      logic [AW-1:0] expAddr;
      logic [1:0]    expRvalid;
      logic [AW-1:0] expRdAddr;
      logic          chkWr;
   } vecA_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   logic [1:0]      reqA, weA, grantA, rvalidA;
   logic [2*AW-1:0] addrA;
   logic [2*DW-1:0] wdataA;
   logic [DW-1:0]   rdataA, vramWrA;
   logic [DW-1:0]   vramRdA = '0;
   logic            enA, weaA;
   logic [AW-1:0]   vAddrA;

   logic [3:0]      reqB, grantB, rvalidB;
   logic [15:0]     rdataB, vramWrB;
   logic            enB, weaB;
   logic [AW-1:0]   vAddrB;

   logic [2:0]      reqC, grantC, rvalidC;
   logic [15:0]     rdataC, vramWrC;
   logic            enC, weaC;
   logic [AW-1:0]   vAddrC;

   vram_arbiter #(.N_CH(2), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .MODE(0)) dutA (
      .clk(clk), .rst(rst), .req(reqA), .we(weA), .addr(addrA), .wdata(wdataA),
      .grant(grantA), .rvalid(rvalidA), .rdata(rdataA),
      .to_vram_en(enA), .to_vram_wea(weaA), .to_vram_addr(vAddrA),
      .to_vram_write(vramWrA), .from_vram_read(vramRdA)
   );

   vram_arbiter #(.N_CH(4), .DATA_W(16), .ADDR_W(AW), .RD_LAT(1), .MODE(1)) dutB (
      .clk(clk), .rst(rst), .req(reqB), .we(4'b0000), .addr({4*AW{1'b0}}), .wdata(64'h0),
      .grant(grantB), .rvalid(rvalidB), .rdata(rdataB),
      .to_vram_en(enB), .to_vram_wea(weaB), .to_vram_addr(vAddrB),
      .to_vram_write(vramWrB), .from_vram_read(16'h0)
   );

   vram_arbiter #(.N_CH(3), .DATA_W(16), .ADDR_W(AW), .RD_LAT(1), .MODE(0)) dutC (
      .clk(clk), .rst(rst), .req(reqC), .we(3'b000), .addr({3*AW{1'b0}}), .wdata(48'h0),
      .grant(grantC), .rvalid(rvalidC), .rdata(rdataC),
      .to_vram_en(enC), .to_vram_wea(weaC), .to_vram_addr(vAddrC),
      .to_vram_write(vramWrC), .from_vram_read(16'h0)
   );

   // Each VRAM word is a recognisable pattern derived from its address.
   function automatic logic [DW-1:0] wordOf(input logic [AW-1:0] a);
      return {20{{7'h2B, a, 16'hBEEF}}};
   endfunction

   always @(posedge clk) begin
      if (enA && !weaA) vramRdA <= wordOf(vAddrA);
   end

   vecA_t vecs[$];

   function automatic void addRow(input logic r, input logic [1:0] rq, input logic [1:0] w,
                                  input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                  input logic [1:0] eg, input logic een, input logic ewea,
                                  input logic [AW-1:0] ea, input logic [1:0] erv,
                                  input logic [AW-1:0] era, input logic cw);
      vecA_t v;
      v = '{r, rq, w, a0, a1, eg, een, ewea, ea, erv, era, cw};
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vecA_t v);
      @(posedge clk);
      #1;
      rst    = v.rstN;
      reqA   = v.req;
      weA    = v.we;
      addrA  = {v.a1, v.a0};
   endtask

   initial begin
      logic [DW-1:0] patA5, pat3C;
      logic [3:0]    expGB;
      logic [2:0]    expGC;
      patA5  = {80{8'hA5}};
      pat3C  = {80{8'h3C}};
      rst    = 1'b0;
      reqA   = '0;
      weA    = '0;
      addrA  = '0;
      wdataA = {pat3C, patA5};
      reqB   = '0;
      reqC   = '0;
      repeat (3) @(posedge clk);

      //     rstN req    we     a0      a1      grant  en wea addr    rvalid rdAddr  chkWr
      addRow(0, 2'b00, 2'b00, 9'h000, 9'h000, 2'b00, 0, 0, 9'h000, 2'b00, 9'h000, 0);
      addRow(1, 2'b11, 2'b11, 9'h010, 9'h011, 2'b01, 0, 0, 9'h000, 2'b00, 9'h000, 0);
      addRow(1, 2'b11, 2'b11, 9'h010, 9'h011, 2'b10, 1, 1, 9'h010, 2'b00, 9'h000, 0);
      addRow(1, 2'b11, 2'b11, 9'h010, 9'h011, 2'b01, 1, 1, 9'h011, 2'b00, 9'h000, 0);
      addRow(1, 2'b11, 2'b11, 9'h010, 9'h011, 2'b10, 1, 1, 9'h010, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h010, 9'h011, 2'b00, 1, 1, 9'h011, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h010, 9'h011, 2'b00, 0, 0, 9'h011, 2'b00, 9'h000, 0);
      addRow(1, 2'b10, 2'b00, 9'h010, 9'h1A5, 2'b10, 0, 0, 9'h011, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h010, 9'h1A5, 2'b00, 1, 0, 9'h1A5, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h010, 9'h1A5, 2'b00, 0, 0, 9'h1A5, 2'b10, 9'h1A5, 0);
      addRow(1, 2'b01, 2'b01, 9'h003, 9'h1A5, 2'b01, 0, 0, 9'h1A5, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h003, 9'h1A5, 2'b00, 1, 1, 9'h003, 2'b00, 9'h000, 1);
      addRow(1, 2'b00, 2'b00, 9'h003, 9'h1A5, 2'b00, 0, 0, 9'h003, 2'b00, 9'h000, 1);
      addRow(1, 2'b11, 2'b00, 9'h040, 9'h041, 2'b10, 0, 0, 9'h003, 2'b00, 9'h000, 0);
      addRow(1, 2'b11, 2'b00, 9'h040, 9'h041, 2'b01, 1, 0, 9'h041, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h040, 9'h041, 2'b00, 1, 0, 9'h040, 2'b10, 9'h041, 0);
      addRow(1, 2'b00, 2'b00, 9'h040, 9'h041, 2'b00, 0, 0, 9'h040, 2'b01, 9'h040, 0);
      addRow(1, 2'b00, 2'b00, 9'h040, 9'h041, 2'b00, 0, 0, 9'h040, 2'b00, 9'h000, 0);
      addRow(1, 2'b01, 2'b00, 9'h077, 9'h041, 2'b01, 0, 0, 9'h040, 2'b00, 9'h000, 0);
      addRow(0, 2'b01, 2'b00, 9'h077, 9'h041, 2'b00, 1, 0, 9'h077, 2'b00, 9'h000, 0);
      addRow(1, 2'b11, 2'b11, 9'h077, 9'h041, 2'b01, 0, 0, 9'h000, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h077, 9'h041, 2'b00, 1, 1, 9'h077, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h077, 9'h041, 2'b00, 0, 0, 9'h077, 2'b00, 9'h000, 0);
      addRow(1, 2'b00, 2'b00, 9'h077, 9'h041, 2'b00, 0, 0, 9'h077, 2'b00, 9'h000, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("row%0d grant", i), DW'(grantA), DW'(vecs[i].expGrant));
         checkOutput($sformatf("row%0d en", i), DW'(enA), DW'(vecs[i].expEn));
         checkOutput($sformatf("row%0d wea", i), DW'(weaA), DW'(vecs[i].expWea));
         checkOutput($sformatf("row%0d addr", i), DW'(vAddrA), DW'(vecs[i].expAddr));
         checkOutput($sformatf("row%0d rvalid", i), DW'(rvalidA), DW'(vecs[i].expRvalid));
         if (vecs[i].expRvalid != 2'b00)
            checkOutput($sformatf("row%0d rdata", i), rdataA, wordOf(vecs[i].expRdAddr));
         if (vecs[i].chkWr)
            checkOutput($sformatf("row%0d wrdata", i), vramWrA, patA5);
      end

      // Second reset, then TDM idle-slot / fairness on B and wrap-and-hold on C together.
      @(posedge clk);
      #1;
      rst  = 1'b0;
      reqA = '0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(posedge clk);
         #1;
         rst  = 1'b1;
         reqB = (k < 12) ? 4'b0100 : 4'b1111;
         reqC = (k == 0) ? 3'b100 : ((k < 4) ? 3'b011 : 3'b000);
         @(negedge clk);
         if (k < 12) begin
            expGB = ((k % 4) == 2) ? 4'b0100 : 4'b0000;
            checkOutput($sformatf("tdm k%0d en", k), DW'(enB), DW'((k % 4) == 3));
         end else begin
            expGB = 4'b0001 << (k % 4);
         end
         checkOutput($sformatf("tdm k%0d grant", k), DW'(grantB), DW'(expGB));
         case (k)
            0:       expGC = 3'b100;
            1:       expGC = 3'b001;
            2:       expGC = 3'b010;
            3:       expGC = 3'b001;
            default: expGC = 3'b000;
         endcase
         checkOutput($sformatf("wrap k%0d grant", k), DW'(grantC), DW'(expGC));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of requesting channels, 1..8.
REQ-002 SHALL have parameter DATA_W, default 640: VRAM word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 9: VRAM address width in bits.
REQ-004 SHALL have parameter RD_LAT, default 1: VRAM read latency in cycles, 1..4.
REQ-005 SHALL have parameter MODE, default 0: 0 = round-robin, 1 = fixed TDM slots.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-008 SHALL have port req  input  N_CH  per-channel access request.
REQ-009 SHALL have port we  input  N_CH  per-channel write enable; 0 means read.
REQ-010 SHALL have port addr  input  N_CH*ADDR_W  per-channel address; channel k uses bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port wdata  input  N_CH*DATA_W  per-channel write data, packed the same way.
REQ-012 SHALL have port grant  output  N_CH  one-hot; the request is accepted on this clock edge.
REQ-013 SHALL have port rvalid  output  N_CH  rdata holds the read result for this channel.
REQ-014 SHALL have port rdata  output  DATA_W  read data, broadcast to all channels.
REQ-015 SHALL have port to_vram_en, to_vram_wea  output  1 each  VRAM enable and write enable.
REQ-016 SHALL have port to_vram_addr  output  ADDR_W, and port to_vram_write  output  DATA_W  VRAM address and write data.
REQ-017 SHALL have port from_vram_read  input  DATA_W  VRAM read data.

Function
REQ-018 SHALL compute grant combinationally from req and arbiter state, at most one bit set, and grant only a channel whose req is 1.
REQ-019 SHALL, in MODE 0, grant the first requesting channel at or after the priority pointer, searching upward with wrap from N_CH-1 to 0.
REQ-020 SHALL, in MODE 0, move the pointer to (granted index + 1) mod N_CH after each grant, and hold the pointer when there is no grant.
REQ-021 SHALL, in MODE 1, advance the slot counter 0..N_CH-1 every cycle with wrap, and grant only the slot owner, and only if it is requesting. Unused slots stay idle.
REQ-022 SHALL register the granted channel's addr, wdata and we into the to_vram_* outputs one cycle after grant, with to_vram_en=1.
REQ-023 SHALL drive to_vram_en=0 and to_vram_wea=0 in any cycle after a no-grant cycle, and hold addr and write data at their last values.
REQ-024 SHALL, for a granted read, assert rvalid[k] for exactly one cycle, 1+RD_LAT cycles after grant, with rdata = from_vram_read in that cycle.
REQ-025 SHALL keep rvalid at 0 for granted writes.
REQ-026 SHALL pipeline back-to-back grants: one access per cycle, with reads of different channels returning in grant order.
REQ-027 SHALL, when N_CH=1, give the single channel a grant in every cycle it requests.
REQ-028 SHALL guarantee that, with all channels requesting continuously, each channel is granted exactly once per N_CH cycles in both modes.

Reset
REQ-029 SHALL, on any rising clk edge with rst=0, set pointer=0, slot=0, to_vram_en=0, to_vram_wea=0, to_vram_addr=0 and to_vram_write=0.
REQ-030 SHALL force grant=0 and rvalid=0 while rst=0.
REQ-031 SHALL discard read returns in flight when reset is asserted, so no rvalid appears after rst is released for reads granted before it.
REQ-032 SHALL allow the first grant in the first cycle with rst=1; in that cycle channel 0 has highest priority.

Verification
REQ-033 Round-robin fairness: MODE 0, N_CH=2, req=2'b11 held for 4 cycles after reset -> grant = 01, 10, 01, 10.
REQ-034 Read latency: MODE 0, RD_LAT=1, channel 1 reads addr 9'h1A5 -> next cycle to_vram_en=1, wea=0, addr=9'h1A5; rvalid=2'b10 two cycles after grant, with rdata = VRAM word.
REQ-035 Write path: channel 0 writes addr 9'h003 with wdata = 640'hA5 repeated -> one cycle later wea=1, addr=9'h003, to_vram_write matches; rvalid stays 0.
REQ-036 TDM idle slot: MODE 1, N_CH=4, only channel 2 requests continuously -> grant=4'b0100 once every 4 cycles; to_vram_en=1 in 1 of every 4 cycles.
REQ-037 Reset mid-read: grant a read, then drive rst=0 on the next edge -> to_vram_en=0, to_vram_wea=0, no rvalid ever returned for that read; after rst=1, pointer=0.
REQ-038 Wrap and hold: MODE 0, N_CH=3, only channel 2 requests, then req=3'b011 -> channel 2 granted; pointer wraps to 0; channel 0 granted next, then channel 1.
